tcam_update_ctrl: RTL and testbench

- Sequencer and arbiter in front of the fractured LUTRAM TCAM array (W-bit key, D entries, 5-bit slices, one write-enable per 8-entry group).
- Shares the array's key bus between two users: search requests, and rule-group commits.
- A commit is expanded into a 32-cycle address sweep. In each sweep cycle the block drives the slice address on sk and the per-slice match bits for the 8 staged rules on the rules bus.
- Sits between the host/config interface and the TCAM instance. The TCAM itself is unchanged.

---
 rtl/tcam_update_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_tcam_update_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_update_ctrl.sv
// Key-bus arbiter and rule-group commit sequencer in front of a fractured LUTRAM TCAM.
// Optional macro HIT_ENCODE_EN adds res_hit/res_idx priority-encoded hit outputs.
module tcam_update_ctrl #(
  parameter int W         = 160,
  parameter int D         = 64,
  parameter int MATCH_LAT = 1,
  localparam int NS       = W / 5,
  localparam int NG       = D / 8,
  localparam int GW       = (NG > 1) ? $clog2(NG) : 1,
  localparam int IW       = (D > 1) ? $clog2(D) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [2:0]       upd_slot,
  input  logic [W-1:0]     upd_value,
  input  logic [W-1:0]     upd_mask,
  input  logic             upd_del,
  input  logic             upd_commit,
  input  logic [GW-1:0]    upd_group,
  input  logic             srch_valid,
  output logic             srch_ready,
  input  logic [W-1:0]     srch_key,
  output logic             res_valid,
  output logic [D-1:0]     res_match,
  output logic [W-1:0]     tcam_sk,
  output logic [NG-1:0]    tcam_we,
  output logic [NS*8-1:0]  tcam_rules,
  input  logic [D-1:0]     tcam_match,
  output logic             busy
`ifdef HIT_ENCODE_EN
  ,
  output logic             res_hit,
  output logic [IW-1:0]    res_idx
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_WRITE} state_t;

  localparam int LP = (MATCH_LAT < 1) ? 1 : MATCH_LAT;

  state_t            state_q, state_d;
  logic [4:0]        a_q, a_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic [7:0]        vld_q, vld_d;
  logic [W-1:0]      val_q [8];
  logic [W-1:0]      val_d [8];
  logic [W-1:0]      msk_q [8];
  logic [W-1:0]      msk_d [8];
  logic [LP-1:0]     vp_q, vp_d;
  logic              res_valid_q, res_valid_d;
  logic [D-1:0]      res_match_q, res_match_d;
  logic [W-1:0]      sk_q, sk_d;
  logic [NG-1:0]     we_q, we_d;
  logic [NS*8-1:0]   rules_q, rules_d;
  logic              upd_acc, srch_acc;

  // Handshakes: a beat transfers on a cycle where valid && ready are both high;
  // ready never depends on anything but state and, for search, the same-cycle commit request.
  assign upd_ready  = (state_q == S_IDLE);
  assign srch_ready = (state_q == S_IDLE) && !(upd_valid && upd_commit);
  assign upd_acc    = upd_valid && upd_ready;
  assign srch_acc   = srch_valid && srch_ready;
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    grp_d   = grp_q;
    vld_d   = vld_q;
    val_d   = val_q;
    msk_d   = msk_q;
    if (upd_acc) begin
      vld_d[upd_slot] = !upd_del;
      if (!upd_del) begin
        val_d[upd_slot] = upd_value;
        msk_d[upd_slot] = upd_mask;
      end
      if (upd_commit) begin
        grp_d   = upd_group;
        a_d     = 5'd0;
        state_d = (MATCH_LAT == 0) ? S_WRITE : S_DRAIN;
      end
    end
    case (state_q)
      S_DRAIN: begin
        if (a_q == 5'(MATCH_LAT - 1)) begin
          state_d = S_WRITE;
          a_d     = 5'd0;
        end else begin
          a_d = a_q + 5'd1;
        end
      end
      S_WRITE: begin
        a_d = a_q + 5'd1;
        if (a_q == 5'd31) begin
          state_d = S_IDLE;
          vld_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Key-bus outputs are computed from the next state so the registered sweep
  // address, write enable and rule bits line up with state_q == S_WRITE.
  always_comb begin
    sk_d    = sk_q;
    we_d    = '0;
    rules_d = '0;
    if (state_d == S_WRITE) begin
      sk_d        = {NS{a_d}};
      we_d[grp_d] = 1'b1;
      for (int i = 0; i < NS; i++) begin
        for (int j = 0; j < 8; j++) begin
          rules_d[i*8+j] = vld_d[j] &&
            (((a_d ^ val_d[j][i*5+:5]) & msk_d[j][i*5+:5]) == 5'd0);
        end
      end
    end else if (srch_acc) begin
      sk_d = srch_key;
    end
  end

  // The sk register is the first stage of the match latency; tcam_match is
  // sampled once the request has spent LP cycles in flight.
  always_comb begin
    vp_d[0] = srch_acc;
    for (int k = 1; k < LP; k++) begin
      vp_d[k] = vp_q[k-1];
    end
    res_valid_d = vp_q[LP-1];
    res_match_d = vp_q[LP-1] ? tcam_match : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= 5'd0;
      grp_q       <= '0;
      vld_q       <= '0;
      vp_q        <= '0;
      res_valid_q <= 1'b0;
      res_match_q <= '0;
      sk_q        <= '0;
      we_q        <= '0;
      rules_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      grp_q       <= grp_d;
      vld_q       <= vld_d;
      vp_q        <= vp_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      sk_q        <= sk_d;
      we_q        <= we_d;
      rules_q     <= rules_d;
    end
  end

  // Slot payloads are qualified by vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    val_q <= val_d;
    msk_q <= msk_d;
  end

  assign res_valid  = res_valid_q;
  assign res_match  = res_match_q;
  assign tcam_sk    = sk_q;
  assign tcam_we    = we_q;
  assign tcam_rules = rules_q;

`ifdef HIT_ENCODE_EN
  always_comb begin
    res_hit = |res_match_q;
    res_idx = '0;
    for (int e = D - 1; e >= 0; e--) begin
      if (res_match_q[e]) res_idx = IW'(e);
    end
  end
`endif

endmodule

// File: tb/tb_tcam_update_ctrl.sv
// Directed bench for tcam_update_ctrl with a behavioural fractured-LUTRAM TCAM
// (combinational read from the registered key, i.e. MATCH_LAT = 1).
module tb_tcam_update_ctrl;
  localparam int W  = 160;
  localparam int D  = 64;
  localparam int NS = W / 5;
  localparam int NG = D / 8;

  logic            clk;
  logic            reset;
  logic            upd_valid;
  logic            upd_ready;
  logic [2:0]      upd_slot;
  logic [W-1:0]    upd_value;
  logic [W-1:0]    upd_mask;
  logic            upd_del;
  logic            upd_commit;
  logic [2:0]      upd_group;
  logic            srch_valid;
  logic            srch_ready;
  logic [W-1:0]    srch_key;
  logic            res_valid;
  logic [D-1:0]    res_match;
  logic [W-1:0]    tcam_sk;
  logic [NG-1:0]   tcam_we;
  logic [NS*8-1:0] tcam_rules;
  logic [D-1:0]    tcam_match;
  logic            busy;
`ifdef HIT_ENCODE_EN
  logic            res_hit;
  logic [5:0]      res_idx;
`endif

  int total;
  int bad;
  int busy_cnt;
  logic clr_tbl;
  logic [W-1:0] keys [3];
  logic [D-1:0] exp_m [3];
  logic [W-1:0] key;
  logic [W-1:0] y_val;
  logic [W-1:0] z_val;

  tcam_update_ctrl #(.W(W), .D(D), .MATCH_LAT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_slot   (upd_slot),
    .upd_value  (upd_value),
    .upd_mask   (upd_mask),
    .upd_del    (upd_del),
    .upd_commit (upd_commit),
    .upd_group  (upd_group),
    .srch_valid (srch_valid),
    .srch_ready (srch_ready),
    .srch_key   (srch_key),
    .res_valid  (res_valid),
    .res_match  (res_match),
    .tcam_sk    (tcam_sk),
    .tcam_we    (tcam_we),
    .tcam_rules (tcam_rules),
    .tcam_match (tcam_match),
    .busy       (busy)
`ifdef HIT_ENCODE_EN
    ,
    .res_hit    (res_hit),
    .res_idx    (res_idx)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // TCAM model: per slice a 32-deep table of D enable bits; an entry matches
  // when every slice's table bit at that slice's key value is set.
  logic [D-1:0] tbl [NS][32];

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      for (int a = 0; a < 32; a++) begin
        if (clr_tbl) tbl[i][a] <= '0;
      end
    end
    if (!clr_tbl) begin
      for (int g = 0; g < NG; g++) begin
        if (tcam_we[g]) begin
          for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < 8; j++) begin
              tbl[i][tcam_sk[i*5+:5]][g*8+j] <= tcam_rules[i*8+j];
            end
          end
        end
      end
    end
  end

  always_comb begin
    tcam_match = '1;
    for (int i = 0; i < NS; i++) begin
      tcam_match = tcam_match & tbl[i][tcam_sk[i*5+:5]];
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rep5(input logic [4:0] a);
    rep5 = {NS{a}};
  endfunction

  function automatic logic [W-1:0] rkey();
    rkey = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic stage(input logic [2:0] slot, input logic [W-1:0] value,
                       input logic [W-1:0] mask, input logic del,
                       input logic commit, input logic [2:0] group);
    upd_valid  = 1'b1;
    upd_slot   = slot;
    upd_value  = value;
    upd_mask   = mask;
    upd_del    = del;
    upd_commit = commit;
    upd_group  = group;
    tick();
    upd_valid  = 1'b0;
    upd_commit = 1'b0;
    upd_del    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 100 && busy; n++) tick();
    check(tag, busy, 1'b0);
  endtask

  task automatic search1(input logic [W-1:0] k, input logic [D-1:0] exp, input string tag);
    srch_valid = 1'b1;
    srch_key   = k;
    tick();
    srch_valid = 1'b0;
    tick();
    check({tag, "_v"}, res_valid, 1'b1);
    check(tag, res_match, exp);
  endtask

  // Directed sequence
  initial begin
    total = 0;
    bad = 0;
    busy_cnt = 0;
    clr_tbl = 1'b1;
    reset = 1'b1;
    upd_valid = 1'b0;
    upd_slot = '0;
    upd_value = '0;
    upd_mask = '0;
    upd_del = 1'b0;
    upd_commit = 1'b0;
    upd_group = '0;
    srch_valid = 1'b0;
    srch_key = '0;
    repeat (3) tick();
    reset = 1'b0;
    clr_tbl = 1'b0;
    tick();

    check("rst_upd_ready", upd_ready, 1'b1);
    check("rst_srch_ready", srch_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_match", res_match, '0);
    check("rst_sk", tcam_sk, '0);
    check("rst_we", tcam_we, '0);
    check("rst_rules", tcam_rules, '0);
    check("rst_busy", busy, 1'b0);

    // Commit slot 3 of group 2 (value 0, exact) with a competing search.
    upd_valid  = 1'b1;
    upd_slot   = 3'd3;
    upd_value  = '0;
    upd_mask   = '1;
    upd_del    = 1'b0;
    upd_commit = 1'b1;
    upd_group  = 3'd2;
    srch_valid = 1'b1;
    srch_key   = '0;
    #1;
    check("srch_blocked_by_commit", srch_ready, 1'b0);
    check("upd_ready_commit", upd_ready, 1'b1);
    tick();
    upd_valid  = 1'b0;
    upd_commit = 1'b0;
    check("drain_busy", busy, 1'b1);
    check("drain_we", tcam_we, '0);
    check("drain_srch_ready", srch_ready, 1'b0);
    check("drain_upd_ready", upd_ready, 1'b0);
    busy_cnt = 1;
    tick();
    for (int k = 0; k < 32; k++) begin
      check("write_we_g2", tcam_we, 8'h04);
      check("write_no_res", res_valid, 1'b0);
      check("write_srch_ready", srch_ready, 1'b0);
      if (k == 0) begin
        check("write_sk_a0", tcam_sk, rep5(5'd0));
        check("write_rules_a0", tcam_rules, {NS{8'h08}});
      end
      if (k == 17) begin
        check("write_sk_a17", tcam_sk, rep5(5'd17));
        check("write_rules_a17", tcam_rules, '0);
      end
      if (busy) busy_cnt++;
      tick();
    end
    check("busy_len", busy_cnt, 33);
    check("post_write_busy", busy, 1'b0);
    check("post_write_we", tcam_we, '0);
    check("post_write_srch_ready", srch_ready, 1'b1);
    tick();
    srch_key = {{(W-1){1'b0}}, 1'b1};
    check("res_latency", res_valid, 1'b0);
    tick();
    srch_valid = 1'b0;
    check("key0_v", res_valid, 1'b1);
    check("key0_match", res_match, 64'h0000_0000_0008_0000);
    tick();
    check("key1_v", res_valid, 1'b1);
    check("key1_match", res_match, '0);
    tick();
    check("res_idle", res_valid, 1'b0);

    // Group 0 slot 0 as full wildcard; three back-to-back searches.
    stage(3'd0, rkey(), '0, 1'b0, 1'b1, 3'd0);
    wait_idle("idle_g0");
    for (int i = 0; i < 3; i++) begin
      keys[i]  = rkey();
      exp_m[i] = (keys[i] == '0) ? 64'h0000_0000_0008_0001 : 64'h1;
    end
    srch_valid = 1'b1;
    srch_key = keys[0];
    tick();
    srch_key = keys[1];
    tick();
    check("b2b0_v", res_valid, 1'b1);
    check("b2b0_match", res_match, exp_m[0]);
    srch_key = keys[2];
    tick();
    check("b2b1_v", res_valid, 1'b1);
    check("b2b1_match", res_match, exp_m[1]);
    srch_valid = 1'b0;
    tick();
    check("b2b2_v", res_valid, 1'b1);
    check("b2b2_match", res_match, exp_m[2]);
    tick();
    check("b2b_end", res_valid, 1'b0);

    // Stage slot 5 of group 1, then delete it in the commit beat.
    stage(3'd5, rep5(5'd7), '1, 1'b0, 1'b0, 3'd1);
    stage(3'd5, rep5(5'd7), '1, 1'b1, 1'b1, 3'd1);
    wait_idle("idle_g1");
    for (int v = 0; v < 32; v++) begin
      key = rep5(5'd7);
      key[4:0] = 5'(v);
      search1(key, 64'h1, "del_sweep");
    end

    // Reset in the middle of a sweep of group 3.
    y_val = rep5(5'd20);
    z_val = rep5(5'd25);
    stage(3'd2, y_val, '1, 1'b0, 1'b0, 3'd3);
    stage(3'd4, z_val, '1, 1'b0, 1'b1, 3'd3);
    tick();
    repeat (10) tick();
    check("a10_sk", tcam_sk, rep5(5'd10));
    check("a10_we", tcam_we, 8'h08);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_we", tcam_we, '0);
    check("abort_busy", busy, 1'b0);
    check("abort_upd_ready", upd_ready, 1'b1);
    check("abort_srch_ready", srch_ready, 1'b1);
    check("abort_rules", tcam_rules, '0);
    stage(3'd0, '0, '0, 1'b1, 1'b1, 3'd3);
    wait_idle("idle_g3");
    search1(y_val, 64'h1, "staging_dropped_y");
    search1(z_val, 64'h1, "staging_dropped_z");

`ifdef HIT_ENCODE_EN
    stage(3'd0, '0, '0, 1'b1, 1'b1, 3'd0);
    wait_idle("idle_hit0");
    stage(3'd5, rep5(5'd9), '1, 1'b0, 1'b1, 3'd1);
    wait_idle("idle_hit1");
    stage(3'd0, rep5(5'd9), '1, 1'b0, 1'b1, 3'd5);
    wait_idle("idle_hit5");
    search1(rep5(5'd9), 64'h0000_0100_0000_2000, "hit_match");
    check("hit_flag", res_hit, 1'b1);
    check("hit_idx", res_idx, 6'd13);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
